// File: rtl/exec_unit.sv
// Multi-cycle execution unit: fetches one instruction byte (plus an immediate for LDI),
// reads two register-file operands, executes ALU/shift-add multiply and writes back once.
module exec_unit #(
  parameter int MUL_EN = 1
) (
  input  logic       CLK,
  input  logic       areset,
  input  logic       instr_valid,
  input  logic [7:0] instr,
  output logic       instr_ready,
  output logic [1:0] rf_sel_a,
  output logic [1:0] rf_sel_b,
  input  logic [7:0] rf_data_a,
  input  logic [7:0] rf_data_b,
  output logic       rf_we,
  output logic [1:0] rf_sel_e,
  output logic [7:0] rf_wdata,
  output logic       flag_z,
  output logic       flag_c,
  output logic       flag_n,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_IMM,
    S_EXEC,
    S_MUL,
    S_WB
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [7:0]  ir;
  logic [7:0]  result;
  logic [15:0] mul_a;
  logic [7:0]  mul_b;
  logic [15:0] mul_acc;
  logic [15:0] mul_sum;
  logic [2:0]  mul_cnt;
  logic [7:0]  alu_res;
  logic        alu_c;
  logic [3:0]  in_op;
  logic        in_exec_op;

  assign in_op      = instr[7:4];
  assign in_exec_op = (in_op <= 4'h8) || ((in_op == 4'hA) && (MUL_EN != 0));

  assign rf_sel_a = ir[3:2];
  assign rf_sel_b = ir[1:0];
  assign rf_wdata = result;

  always_ff @(posedge CLK) begin
    if (areset) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state  = state;
    instr_ready = 1'b0;
    rf_we       = 1'b0;
    busy        = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          if (in_op == 4'h9)   next_state = S_IMM;
          else if (in_exec_op) next_state = S_EXEC;
        end
      end
      S_IMM: begin
        instr_ready = 1'b1;
        if (instr_valid) next_state = S_WB;
      end
      S_EXEC:  next_state = (ir[7:4] == 4'hA) ? S_MUL : S_WB;
      S_MUL:   if (mul_cnt == 3'd7) next_state = S_WB;
      S_WB: begin
        rf_we      = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    alu_res = 8'h00;
    alu_c   = 1'b0;
    case (ir[7:4])
      4'h0: {alu_c, alu_res} = {1'b0, rf_data_a} + {1'b0, rf_data_b};
      4'h1: begin
        alu_res = rf_data_a - rf_data_b;
        alu_c   = (rf_data_a < rf_data_b);
      end
      4'h2: alu_res = rf_data_a & rf_data_b;
      4'h3: alu_res = rf_data_a | rf_data_b;
      4'h4: alu_res = rf_data_a ^ rf_data_b;
      4'h5: alu_res = ~rf_data_b;
      4'h6: begin
        alu_res = {rf_data_b[6:0], 1'b0};
        alu_c   = rf_data_b[7];
      end
      4'h7: begin
        alu_res = {1'b0, rf_data_b[7:1]};
        alu_c   = rf_data_b[0];
      end
      4'h8: alu_res = rf_data_b;
      default: ;
    endcase
  end

  // One shift-add step: multiplicand shifts left, multiplier shifts right.
  assign mul_sum = mul_acc + (mul_b[0] ? mul_a : 16'h0000);

  always_ff @(posedge CLK) begin
    if (areset) begin
      ir       <= 8'h00;
      result   <= 8'h00;
      rf_sel_e <= 2'b00;
      flag_z   <= 1'b0;
      flag_c   <= 1'b0;
      flag_n   <= 1'b0;
      mul_a    <= 16'h0000;
      mul_b    <= 8'h00;
      mul_acc  <= 16'h0000;
      mul_cnt  <= 3'd0;
    end else begin
      case (state)
        S_IDLE: if (instr_valid) ir <= instr;
        S_IMM: begin
          if (instr_valid) begin
            result   <= instr;
            rf_sel_e <= ir[3:2];
          end
        end
        S_EXEC: begin
          if (ir[7:4] == 4'hA) begin
            mul_a   <= {8'h00, rf_data_a};
            mul_b   <= rf_data_b;
            mul_acc <= 16'h0000;
            mul_cnt <= 3'd0;
          end else begin
            result   <= alu_res;
            rf_sel_e <= ir[3:2];
            if (ir[7:4] != 4'h8) begin
              flag_z <= (alu_res == 8'h00);
              flag_c <= alu_c;
              flag_n <= alu_res[7];
            end
          end
        end
        S_MUL: begin
          mul_acc <= mul_sum;
          mul_a   <= mul_a << 1;
          mul_b   <= mul_b >> 1;
          mul_cnt <= mul_cnt + 3'd1;
          if (mul_cnt == 3'd7) begin
            result   <= mul_sum[7:0];
            rf_sel_e <= ir[3:2];
            flag_z   <= (mul_sum[7:0] == 8'h00);
            flag_c   <= (mul_sum[15:8] != 8'h00);
            flag_n   <= mul_sum[7];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Bench for exec_unit: owns the register file, predicts every write-back with an
// arithmetic reference model and checks it from an independent monitor.
module tb_exec_unit;

  typedef struct {
    logic [1:0] sel;
    logic [7:0] data;
    logic       z;
    logic       c;
    logic       n;
    int         cyc;
  } exp_t;

  logic       CLK = 1'b0;
  logic       areset;
  logic       instr_valid;
  logic       instr_valid0;
  logic [7:0] instr;
  logic       instr_ready, busy, rf_we, flag_z, flag_c, flag_n;
  logic [1:0] rf_sel_a, rf_sel_b, rf_sel_e;
  logic [7:0] rf_data_a, rf_data_b, rf_wdata;
  logic       r0_ready, r0_busy, r0_we, r0_z, r0_c, r0_n;
  logic [1:0] r0_sel_a, r0_sel_b, r0_sel_e;
  logic [7:0] r0_wdata;

  logic [7:0] rf [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] mrf [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
  logic       mz = 1'b0, mc = 1'b0, mn = 1'b0;
  exp_t       expq [$];
  exp_t       mon_e;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;

  always #5 CLK = ~CLK;

  exec_unit #(.MUL_EN(1)) dut (
    .CLK(CLK), .areset(areset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .rf_sel_a(rf_sel_a), .rf_sel_b(rf_sel_b),
    .rf_data_a(rf_data_a), .rf_data_b(rf_data_b), .rf_we(rf_we),
    .rf_sel_e(rf_sel_e), .rf_wdata(rf_wdata), .flag_z(flag_z),
    .flag_c(flag_c), .flag_n(flag_n), .busy(busy)
  );

  exec_unit #(.MUL_EN(0)) dut_nomul (
    .CLK(CLK), .areset(areset), .instr_valid(instr_valid0), .instr(instr),
    .instr_ready(r0_ready), .rf_sel_a(r0_sel_a), .rf_sel_b(r0_sel_b),
    .rf_data_a(8'h00), .rf_data_b(8'h00), .rf_we(r0_we),
    .rf_sel_e(r0_sel_e), .rf_wdata(r0_wdata), .flag_z(r0_z),
    .flag_c(r0_c), .flag_n(r0_n), .busy(r0_busy)
  );

  assign rf_data_a = rf[rf_sel_a];
  assign rf_data_b = rf[rf_sel_b];

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (rf_we) rf[rf_sel_e] <= rf_wdata;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every write-back must match the oldest outstanding prediction, in content and timing.
  always @(negedge CLK) begin
    if (rf_we) begin
      if (expq.size() == 0) begin
        checkOutput("unexpected_write", 32'd1, 32'd0);
      end else begin
        mon_e = expq.pop_front();
        checkOutput("wb_sel",   32'(rf_sel_e), 32'(mon_e.sel));
        checkOutput("wb_data",  32'(rf_wdata), 32'(mon_e.data));
        checkOutput("wb_flag_z", 32'(flag_z),  32'(mon_e.z));
        checkOutput("wb_flag_c", 32'(flag_c),  32'(mon_e.c));
        checkOutput("wb_flag_n", 32'(flag_n),  32'(mon_e.n));
        checkOutput("wb_cycle", 32'(cyc),      32'(mon_e.cyc));
      end
    end
  end

  task automatic model_exec(input logic [7:0] ins, input logic [7:0] imm, input int acc_cyc);
    int   op = int'(ins[7:4]);
    int   a  = int'(mrf[ins[3:2]]);
    int   b  = int'(mrf[ins[1:0]]);
    int   r  = 0;
    int   lat = 2;
    bit   setf = 1'b1;
    bit   cf = 1'b0;
    exp_t e;
    case (op)
      0:  begin r = a + b; cf = (r > 255); end
      1:  begin r = a - b; cf = (a < b); end
      2:  r = a & b;
      3:  r = a | b;
      4:  r = a ^ b;
      5:  r = 255 - b;
      6:  begin r = b * 2; cf = (b >= 128); end
      7:  begin r = b / 2; cf = (b % 2 == 1); end
      8:  begin r = b; setf = 1'b0; end
      9:  begin r = int'(imm); setf = 1'b0; lat = 1; end
      10: begin r = a * b; cf = (r > 255); lat = 10; end
      default: return;
    endcase
    r = r & 255;
    mrf[ins[3:2]] = 8'(r);
    if (setf) begin
      mz = (r == 0);
      mc = cf;
      mn = (r >= 128);
    end
    e.sel  = ins[3:2];
    e.data = 8'(r);
    e.z    = mz;
    e.c    = mc;
    e.n    = mn;
    e.cyc  = acc_cyc + lat;
    expq.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send_byte(input logic [7:0] b, output int acc_cyc, output bit ok);
    int guard = 0;
    ok = 1'b0;
    acc_cyc = 0;
    instr_valid = 1'b1;
    instr = b;
    while (!ok && guard < 200) begin
      @(negedge CLK);
      if (instr_ready) begin
        ok = 1'b1;
        acc_cyc = cyc;
      end
      guard++;
    end
    if (!ok) checkOutput("accept_timeout", 32'd0, 32'd1);
    @(posedge CLK); #1;
    instr_valid = 1'b0;
    instr = 8'($urandom);
  endtask

  task automatic applyStimulus(input logic [7:0] ins, input logic [7:0] imm, input int stall, input bit track);
    int acc_cyc;
    bit ok;
    send_byte(ins, acc_cyc, ok);
    if (!ok) return;
    if (ins[7:4] == 4'h9) begin
      repeat (stall) begin
        @(negedge CLK);
        checkOutput("imm_ready", 32'(instr_ready), 32'd1);
        checkOutput("imm_busy",  32'(busy),        32'd1);
      end
      if (stall > 0) begin
        @(posedge CLK); #1;
      end
      send_byte(imm, acc_cyc, ok);
      if (!ok) return;
    end
    if (track) model_exec(ins, imm, acc_cyc);
  endtask

  task automatic load_reg(input logic [1:0] idx, input logic [7:0] val);
    applyStimulus({4'h9, idx, 2'b00}, val, 0, 1'b1);
  endtask

  task automatic wait_idle();
    int g = 0;
    do begin
      @(negedge CLK);
      g++;
    end while ((busy || expq.size() != 0) && g < 300);
    if (busy || expq.size() != 0) checkOutput("idle_timeout", 32'd1, 32'd0);
    @(posedge CLK); #1;
  endtask

  initial begin
    int n_busy;
    areset = 1'b1;
    instr_valid = 1'b0;
    instr_valid0 = 1'b0;
    instr = 8'h00;
    repeat (3) @(posedge CLK);
    #1 areset = 1'b0;

    @(negedge CLK);
    checkOutput("rst_ready",  32'(instr_ready), 32'd1);
    checkOutput("rst_busy",   32'(busy),        32'd0);
    checkOutput("rst_we",     32'(rf_we),       32'd0);
    checkOutput("rst_sel_a",  32'(rf_sel_a),    32'd0);
    checkOutput("rst_sel_b",  32'(rf_sel_b),    32'd0);
    checkOutput("rst_sel_e",  32'(rf_sel_e),    32'd0);
    checkOutput("rst_wdata",  32'(rf_wdata),    32'd0);
    checkOutput("rst_flags",  32'({flag_z, flag_c, flag_n}), 32'd0);
    @(posedge CLK); #1;

    // ADD with carry out and zero result, then LDI with a stalled immediate
    load_reg(2'd1, 8'h80);
    applyStimulus(8'h98, 8'h80, 3, 1'b1);
    applyStimulus(8'h06, 8'h00, 0, 1'b1);
    wait_idle();
    applyStimulus(8'h98, 8'h7F, 3, 1'b1);
    wait_idle();

    // Multiply without and with high-byte overflow
    load_reg(2'd0, 8'h0F);
    load_reg(2'd3, 8'h11);
    wait_idle();
    applyStimulus(8'hA3, 8'h00, 0, 1'b1);
    n_busy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (!busy) break;
      n_busy++;
    end
    checkOutput("mul_busy_cycles", 32'(n_busy), 32'd10);
    @(posedge CLK); #1;
    load_reg(2'd0, 8'h0F);
    load_reg(2'd3, 8'h20);
    applyStimulus(8'hA3, 8'h00, 0, 1'b1);
    wait_idle();

    // SUB underflow, then back-to-back MOV and a read of the moved register
    load_reg(2'd1, 8'h01);
    load_reg(2'd2, 8'h02);
    applyStimulus(8'h16, 8'h00, 0, 1'b1);
    applyStimulus(8'h84, 8'h00, 0, 1'b1);
    applyStimulus(8'h05, 8'h00, 0, 1'b1);
    wait_idle();

    // Illegal opcode is swallowed without effect
    applyStimulus(8'hF5, 8'h00, 0, 1'b1);
    repeat (3) begin
      @(negedge CLK);
      checkOutput("illegal_busy",  32'(busy),        32'd0);
      checkOutput("illegal_ready", 32'(instr_ready), 32'd1);
      checkOutput("illegal_flags", 32'({flag_z, flag_c, flag_n}), 32'({mz, mc, mn}));
    end
    @(posedge CLK); #1;

    // Reset in the middle of a multiply must abort it without any write
    applyStimulus(8'hA3, 8'h00, 0, 1'b0);
    repeat (3) @(posedge CLK);
    #1 areset = 1'b1;
    @(posedge CLK);
    #1 areset = 1'b0;
    mz = 1'b0; mc = 1'b0; mn = 1'b0;
    @(negedge CLK);
    checkOutput("abort_busy",  32'(busy),        32'd0);
    checkOutput("abort_we",    32'(rf_we),       32'd0);
    checkOutput("abort_ready", 32'(instr_ready), 32'd1);
    checkOutput("abort_flags", 32'({flag_z, flag_c, flag_n}), 32'd0);
    repeat (15) @(negedge CLK);
    @(posedge CLK); #1;

    // MUL_EN=0 instance treats 0xA as a no-op but still executes ADD
    instr = 8'hA5;
    instr_valid0 = 1'b1;
    @(negedge CLK);
    checkOutput("nomul_ready_pre", 32'(r0_ready), 32'd1);
    @(posedge CLK); #1;
    instr_valid0 = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      checkOutput("nomul_busy",  32'(r0_busy),  32'd0);
      checkOutput("nomul_ready", 32'(r0_ready), 32'd1);
      checkOutput("nomul_we",    32'(r0_we),    32'd0);
      checkOutput("nomul_flags", 32'({r0_z, r0_c, r0_n}), 32'd0);
    end
    @(posedge CLK); #1;
    instr = 8'h05;
    instr_valid0 = 1'b1;
    @(posedge CLK); #1;
    instr_valid0 = 1'b0;
    @(negedge CLK);
    checkOutput("nomul_add_busy", 32'(r0_busy), 32'd1);
    repeat (4) @(posedge CLK);
    #1;

    // Randomized instruction stream
    for (int k = 0; k < 150; k++) begin
      applyStimulus(8'($urandom), 8'($urandom), $urandom_range(0, 3), 1'b1);
      repeat ($urandom_range(0, 2)) begin
        @(posedge CLK); #1;
      end
    end
    wait_idle();
    checkOutput("queue_empty", 32'(expq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 SHALL have parameter MUL_EN, default 1; 1 = opcode 0xA is multiply, 0 = opcode 0xA is NOP.
REQ-002 SHALL have port CLK, input, 1, clock; all state updates on rising edge.
REQ-003 SHALL have port areset, input, 1; reset areset, synchronous, active-high; clock CLK.
REQ-004 SHALL have port instr_valid, input, 1; instruction/immediate byte offered.
REQ-005 SHALL have port instr, input, 8; {op[7:4], rd/ra[3:2], rb[1:0]} or immediate byte.
REQ-006 SHALL have port instr_ready, output, 1; byte accepted on edge where instr_valid && instr_ready.
REQ-007 SHALL have ports rf_sel_a and rf_sel_b, output, 2 each; register-file read selectors.
REQ-008 SHALL have ports rf_data_a and rf_data_b, input, 8 each; combinational read data for rf_sel_a/rf_sel_b.
REQ-009 SHALL have ports rf_we (output, 1), rf_sel_e (output, 2) and rf_wdata (output, 8); register-file write port.
REQ-010 SHALL have ports flag_z, flag_c and flag_n, output, 1 each; registered status flags.
REQ-011 SHALL have port busy, output, 1; high in every state except IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, IMM, EXEC, MUL, WB; all outputs registered or decoded from state/latched instruction only.
REQ-013 IDLE: instr_ready=1; on accept, latch instr into IR and transition as follows.
- op 0x9 -> IMM.
- op 0x0-0x8 -> EXEC.
- op 0xA with MUL_EN=1 -> EXEC.
- any other op -> remain IDLE: no write, flags unchanged.
REQ-014 IMM: instr_ready=1; on accept, result=instr -> WB; without valid, hold IMM indefinitely.
REQ-015 EXEC: instr_ready=0; rf_sel_a=IR[3:2], rf_sel_b=IR[1:0]; sample operands A=rf_data_a, B=rf_data_b at end of cycle.
- op 0xA -> MUL.
- all other ops -> WB with result registered.
REQ-016 Ops (8-bit result, wrap-around):
- 0 ADD A+B, C=carry out.
- 1 SUB A-B, C=borrow (A<B).
- 2 AND, 3 OR, 4 XOR, C=0.
- 5 NOT ~B, C=0.
- 6 SHL B<<1, C=B[7].
- 7 SHR B>>1 logical, C=B[0].
- 8 MOV B.
- 9 LDI immediate.
- A MUL low byte of A*B, C=(high byte!=0).
REQ-017 Flags SHALL update on the edge entering WB: Z=(result==0), N=result[7], C per REQ-016; MOV and LDI SHALL leave all flags unchanged.
REQ-018 MUL: shift-add over exactly 8 cycles (iteration counter 0..7), then WB; instr_ready=0 throughout.
REQ-019 WB: exactly one cycle with rf_we=1, rf_sel_e=IR[3:2], rf_wdata=result; then IDLE.
REQ-020 Outside WB, rf_we SHALL be 0; rf_sel_e/rf_wdata hold last values.
REQ-021 Latency from accept edge:
- single-cycle op: EXEC cycle 1, WB cycle 2, instr_ready=1 again cycle 3.
- MUL: WB cycle 10.
- LDI: WB one cycle after immediate accept.
REQ-022 A WB to rd followed by an instruction reading rd SHALL see the new value with no stall (write completes before next EXEC).
REQ-023 instr SHALL be ignored whenever instr_ready=0.

Reset
REQ-024 areset high at a rising edge SHALL force the following, overriding any operation in progress (including mid-MUL and IMM):
- state=IDLE.
- IR=0, result=0, MUL counter/accumulator=0.
- rf_we=0, rf_sel_a/b/e=0, rf_wdata=0.
- flags=0, busy=0.
REQ-025 First cycle after reset release: instr_ready=1, no register-file write pending.

Verification
REQ-026 ADD: r1=0x80, r2=0x80; instr 0x06 -> WB rf_sel_e=1, rf_wdata=0x00; Z=1, C=1, N=0; rf_we high exactly one cycle, 2 cycles after accept.
REQ-027 LDI: 0x98, stall 3 cycles, then 0x7F -> instr_ready stays 1 in IMM; WB r2=0x7F; flags unchanged.
REQ-028 MUL: r0=0x0F, r3=0x11; instr 0xA3 -> busy 10 cycles; rf_wdata=0xFF; C=0, N=1.
- Repeat with r3=0x20 -> rf_wdata=0xE0, C=1.
REQ-029 SUB underflow: r1=0x01, r2=0x02; instr 0x16 -> rf_wdata=0xFF; C=1, N=1, Z=0.
- Back-to-back MOV 0x84 then reads r1 correctly.
REQ-030 Reset during MUL cycle 4 -> next cycle state IDLE, rf_we=0, flags=0; no write ever issued for the aborted op.
REQ-031 Opcode 0xF and opcode 0xA with MUL_EN=0 -> instr_ready stays 1, no rf_we, flags unchanged.
